// File: rtl/demux_stripe_if.sv
// Byte-stream handshake between a byte source and the demux striping controller.
interface demux_stripe_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/demux_stripe_ctrl.sv
// Stripes a serial byte stream across 1, 2 or 4 demux lanes, padding stalled
// partial groups with the idle symbol and counting emitted and padded groups.
module demux_stripe_ctrl #(
  parameter int                 DATA_W    = 8,
  parameter logic [DATA_W-1:0]  IDLE_BYTE = 8'h7C,
  parameter int                 FLUSH_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  demux_stripe_if.slave     s,
  input  logic [1:0]        lane_cfg,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic              valid0,
  output logic              valid1,
  output logic              valid2,
  output logic              valid3,
  output logic              busy,
  output logic              cfg_err,
  output logic [15:0]       grp_cnt,
  output logic [7:0]        pad_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        idle_q, idle_d;
  logic [2:0]        n_q, n_d;
  logic [DATA_W-1:0] hold_q [4];
  logic [DATA_W-1:0] hold_d [4];
  logic [DATA_W-1:0] out_q [4];
  logic [DATA_W-1:0] out_d [4];
  logic [3:0]        vld_q, vld_d;
  logic              cfg_err_q, cfg_err_d;
  logic [15:0]       grp_q, grp_d;
  logic [7:0]        pad_q, pad_d;

  logic [2:0] cfg_n;
  logic [2:0] n_cur;
  logic [3:0] idle_inc;
  logic       accept;
  logic       emit;
  logic       pad;

  // Ready is gated by the raw reset input so nothing is taken while reset is held.
  assign s.in_ready = reset && (state_q != S_PAD);
  assign accept     = s.in_valid && s.in_ready;
  assign idle_inc   = idle_q + 4'd1;

  always_comb begin
    case (lane_cfg)
      2'b00:   cfg_n = 3'd1;
      2'b01:   cfg_n = 3'd2;
      default: cfg_n = 3'd4;
    endcase
  end

  // The width is only re-sampled at the first byte of a group.
  assign n_cur = (state_q == S_IDLE) ? cfg_n : n_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idle_d    = idle_q;
    n_d       = n_q;
    hold_d    = hold_q;
    out_d     = out_q;
    vld_d     = 4'b0000;
    cfg_err_d = cfg_err_q;
    grp_d     = grp_q;
    pad_d     = pad_q;
    emit      = 1'b0;
    pad       = 1'b0;

    case (state_q)
      S_IDLE: begin
        ptr_d  = 2'd0;
        idle_d = 4'd0;
        if (accept) begin
          n_d = cfg_n;
          if (lane_cfg == 2'b11) cfg_err_d = 1'b1;
          if (cfg_n == 3'd1) begin
            emit = 1'b1;
          end else begin
            hold_d[0] = s.in_data;
            ptr_d     = 2'd1;
            state_d   = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (accept) begin
          idle_d = 4'd0;
          if ({1'b0, ptr_q} == n_q - 3'd1) begin
            emit    = 1'b1;
            ptr_d   = 2'd0;
            state_d = S_IDLE;
          end else begin
            hold_d[ptr_q] = s.in_data;
            ptr_d         = ptr_q + 2'd1;
          end
        end else begin
          // An accept in the timeout cycle takes the branch above, so it wins.
          idle_d = idle_inc;
          if (idle_inc == 4'(FLUSH_CYC)) state_d = S_PAD;
        end
      end
      S_PAD: begin
        emit    = 1'b1;
        pad     = 1'b1;
        pad_d   = sat_inc8(pad_q);
        ptr_d   = 2'd0;
        idle_d  = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = 2'd0;
        idle_d  = 4'd0;
      end
    endcase

    if (emit) begin
      grp_d = grp_q + 16'd1;
      for (int i = 0; i < 4; i++) begin
        if (3'(i) >= n_cur) begin
          out_d[i] = '0;
        end else begin
          vld_d[i] = 1'b1;
          if ({1'b0, ptr_q} > 3'(i))
            out_d[i] = hold_q[i];
          else if (pad)
            out_d[i] = IDLE_BYTE;
          else
            out_d[i] = s.in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 2'd0;
      idle_q    <= 4'd0;
      n_q       <= 3'd1;
      vld_q     <= 4'b0000;
      cfg_err_q <= 1'b0;
      grp_q     <= 16'd0;
      pad_q     <= 8'd0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idle_q    <= idle_d;
      n_q       <= n_d;
      vld_q     <= vld_d;
      cfg_err_q <= cfg_err_d;
      grp_q     <= grp_d;
      pad_q     <= pad_d;
      for (int i = 0; i < 4; i++) out_q[i] <= out_d[i];
    end
  end

  // Held bytes are only meaningful below ptr, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) hold_q[i] <= hold_d[i];
  end

  assign out0    = out_q[0];
  assign out1    = out_q[1];
  assign out2    = out_q[2];
  assign out3    = out_q[3];
  assign valid0  = vld_q[0];
  assign valid1  = vld_q[1];
  assign valid2  = vld_q[2];
  assign valid3  = vld_q[3];
  assign busy    = (state_q != S_IDLE);
  assign cfg_err = cfg_err_q;
  assign grp_cnt = grp_q;
  assign pad_cnt = pad_q;

endmodule

// File: tb/tb_demux_stripe_ctrl.sv
// Scoreboard bench for demux_stripe_ctrl: stimulus queues expected groups,
// a negedge monitor pops and compares whenever any lane valid is seen.
module tb_demux_stripe_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  demux_stripe_if #(.DATA_W(8)) bus ();

  logic [1:0]  lane_cfg;
  logic [7:0]  out0, out1, out2, out3;
  logic        valid0, valid1, valid2, valid3;
  logic        busy, cfg_err;
  logic [15:0] grp_cnt;
  logic [7:0]  pad_cnt;

  demux_stripe_ctrl #(.DATA_W(8), .IDLE_BYTE(8'h7C), .FLUSH_CYC(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .s        (bus),
    .lane_cfg (lane_cfg),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .valid0   (valid0),
    .valid1   (valid1),
    .valid2   (valid2),
    .valid3   (valid3),
    .busy     (busy),
    .cfg_err  (cfg_err),
    .grp_cnt  (grp_cnt),
    .pad_cnt  (pad_cnt)
  );

  typedef struct packed {
    logic [31:0] o;
    logic [3:0]  v;
    logic [15:0] g;
    logic [7:0]  p;
  } exp_t;

  exp_t        sbq [$];
  int          checks = 0;
  int          passes = 0;
  logic [15:0] exp_grp = 16'd0;
  logic [7:0]  exp_pad = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic expect_emit(input logic [31:0] o, input logic [3:0] v, input bit padded);
    exp_t e;
    exp_grp = exp_grp + 16'd1;
    if (padded && exp_pad != 8'hFF) exp_pad = exp_pad + 8'd1;
    e.o = o;
    e.v = v;
    e.g = exp_grp;
    e.p = exp_pad;
    sbq.push_back(e);
  endtask

  // Monitor: every emitted group must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && ({valid3, valid2, valid1, valid0} != 4'b0000)) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_emit: got valids %b out %h expected no emit",
                 {valid3, valid2, valid1, valid0}, {out3, out2, out1, out0});
      end else begin
        e = sbq.pop_front();
        chk("emit_lanes",  {out3, out2, out1, out0}, e.o);
        chk("emit_valids", {28'd0, valid3, valid2, valid1, valid0}, {28'd0, e.v});
        chk("emit_grp",    {16'd0, grp_cnt}, {16'd0, e.g});
        chk("emit_pad",    {24'd0, pad_cnt}, {24'd0, e.p});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!ok && n > 20) begin
        $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected 1", n);
        $fatal(1);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    chk("ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_lanes", {out3, out2, out1, out0}, 32'd0);
    chk("rst_valids", {28'd0, valid3, valid2, valid1, valid0}, 32'd0);
    chk("rst_status", {busy, cfg_err, grp_cnt, pad_cnt}, 26'd0);
    reset = 1'b1;
    #1;
    chk("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
    exp_grp = 16'd0;
    exp_pad = 8'd0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    lane_cfg     = 2'b00;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();

    // x4 full group at line rate
    lane_cfg = 2'b10;
    expect_emit(32'h44332211, 4'b1111, 1'b0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("x4_ready_stays", {31'd0, bus.in_ready}, 32'd1);
    idle(3);
    chk("x4_hold_lanes", {out3, out2, out1, out0}, 32'h44332211);
    chk("x4_hold_valids", {28'd0, valid3, valid2, valid1, valid0}, 32'd0);

    // x2 stream, two groups
    lane_cfg = 2'b01;
    expect_emit(32'h0000A1A0, 4'b0011, 1'b0);
    expect_emit(32'h0000A3A2, 4'b0011, 1'b0);
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
    idle(2);

    // accept coinciding with timeout: no pad
    lane_cfg = 2'b10;
    expect_emit(32'h04030201, 4'b1111, 1'b0);
    send(8'h01);
    idle(3);
    send(8'h02);
    chk("race_busy", {31'd0, busy}, 32'd1);
    send(8'h03); send(8'h04);
    idle(1);
    chk("race_no_pad", {24'd0, pad_cnt}, 32'd0);

    // timeout pads the partial group; in_valid in PAD is refused
    expect_emit(32'h7C7C6B5A, 4'b1111, 1'b1);
    send(8'h5A); send(8'h6B);
    idle(4);
    chk("pad_ready_low", {31'd0, bus.in_ready}, 32'd0);
    chk("pad_busy", {31'd0, busy}, 32'd1);
    bus.in_data  = 8'hEE;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("pad_busy_clear", {31'd0, busy}, 32'd0);
    chk("pad_cnt_one", {24'd0, pad_cnt}, 32'd1);
    idle(6);

    // reset mid-group discards held bytes
    lane_cfg = 2'b10;
    send(8'hB1); send(8'hB2); send(8'hB3);
    lane_cfg = 2'b00;
    pulse_reset();
    expect_emit(32'h0000009C, 4'b0001, 1'b0);
    send(8'h9C);
    idle(2);

    // reserved width: x4 and sticky error
    lane_cfg = 2'b11;
    expect_emit(32'hDDCCBBAA, 4'b1111, 1'b0);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    idle(1);
    chk("cfg_err_set", {31'd0, cfg_err}, 32'd1);
    lane_cfg = 2'b00;
    expect_emit(32'h00000055, 4'b0001, 1'b0);
    send(8'h55);
    idle(1);
    chk("cfg_err_sticky", {31'd0, cfg_err}, 32'd1);
    pulse_reset();

    // group counter wrap
    lane_cfg = 2'b00;
    for (int i = 0; i < 65535; i++) begin
      expect_emit({24'd0, 8'(i)}, 4'b0001, 1'b0);
      send(8'(i));
    end
    idle(1);
    chk("grp_max", {16'd0, grp_cnt}, 32'h0000FFFF);
    expect_emit(32'h000000E7, 4'b0001, 1'b0);
    send(8'hE7);
    idle(2);
    chk("grp_wrap", {16'd0, grp_cnt}, 32'd0);

    idle(2);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/demux_stripe_ctrl.md
Name: demux_stripe_ctrl

Overview:
- Byte-striping controller that feeds the 1:4 demux output register stage of the PCIe physical layer.
- Accepts a serial stream of 8-bit bytes with valid/ready handshake and distributes consecutive bytes across 1, 2 or 4 active lanes.
- Presents each complete lane group as one registered output word with per-lane valids.
- Pads partial groups with the idle symbol after a configurable timeout, and keeps group and pad statistics.

Parameters:
- DATA_W, 8, byte width per lane.
- IDLE_BYTE, 8'h7C, pad symbol for unfilled slots (IDL, K28.3 code byte).
- FLUSH_CYC, 4, consecutive no-accept cycles in FILL before a partial group is padded. Legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 clears all state).
- in_data  in  DATA_W  input byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller can accept; transfer occurs when in_valid && in_ready.
- lane_cfg  in  2  lane width: 00=x1, 01=x2, 10=x4, 11=reserved (treated as x4, cfg_err set).
- out0..out3  out  DATA_W each  lane bytes, registered.
- valid0..valid3  out  1 each  lane valid, one-cycle pulse per emitted group.
- busy  out  1  high when a partial group is held (state FILL or PAD).
- cfg_err  out  1  sticky; set when lane_cfg==11 is latched; cleared only by reset.
- grp_cnt  out  16  emitted group count; wraps 16'hFFFF -> 0.
- pad_cnt  out  8  padded group count; saturates at 8'hFF.

Behaviour:
- Reset (reset==0 at a clk edge):
  - out0..3=0, valid0..3=0, in_ready=0 during reset, busy=0, cfg_err=0, grp_cnt=0, pad_cnt=0.
  - State=IDLE, slot pointer ptr=0, idle counter=0, active width N=1.
  - in_ready=1 from the first cycle after reset is released.
  - Reset mid-group discards held bytes; nothing is emitted.
- Width latch:
  - lane_cfg is sampled into N (1/2/4) only in IDLE, at the cycle of the first accept of a group.
  - lane_cfg changes during FILL/PAD have no effect until the next group.
- States:
  - IDLE: ptr=0, in_ready=1.
    - On accept with N=1: emit immediately (see Emit). Stay in IDLE.
    - On accept with N>1: hold[0]<=in_data, ptr<=1, go to FILL.
  - FILL: in_ready=1.
    - On accept: hold[ptr]<=in_data.
      - If ptr==N-1: emit, ptr<=0, go to IDLE.
      - Else ptr<=ptr+1.
    - Each cycle without an accept increments the idle counter. Any accept clears it.
    - When the idle counter reaches FLUSH_CYC: go to PAD.
  - PAD: lasts exactly one cycle, in_ready=0.
    - Slots ptr..N-1 are filled with IDLE_BYTE and the group is emitted.
    - pad_cnt increments (saturating); ptr<=0; go to IDLE.
    - in_valid during PAD is not accepted; the source holds it.
- Emit:
  - Outputs update on the edge after the completing accept, or on the edge leaving PAD. Latency of the last byte to output is 1 cycle.
  - Lanes 0..N-1 get hold bytes in arrival order (the first byte of the group goes to lane 0). validX=1 for X<N.
  - Lanes >=N: outX=0, validX=0.
  - grp_cnt increments on every emit, including padded ones.
  - In every non-emit cycle, all validX=0 and outX hold their last value.
- Back-to-back: at full rate the controller accepts one byte per cycle with no bubbles except the PAD cycle.
- Simultaneous events: an accept in the same cycle the idle counter would reach FLUSH_CYC wins. The byte is stored and the counter clears; no pad occurs.
- busy=1 while in FILL or PAD, 0 in IDLE.

Test Plan:
- x4, FLUSH_CYC=4, bytes 11,22,33,44 on consecutive cycles -> one cycle later out0..3=11,22,33,44, valid0..3=1 for one cycle, grp_cnt=1, in_ready stays 1.
- x2, stream A0,A1,A2,A3 -> two emits: (out0,out1)=(A0,A1), then (A2,A3); valid2/valid3 stay 0; grp_cnt=2.
- x4, bytes 5A,6B then in_valid=0 for 4 cycles -> PAD cycle with in_ready=0, then out0..3=5A,6B,7C,7C with all valids=1, pad_cnt=1, busy back to 0.
- x4, byte 01, in_valid=0 for 3 cycles, byte 02 on the 4th cycle (simultaneous with timeout) -> no pad; group continues; after 03,04 the emit is 01,02,03,04 and pad_cnt=0.
- x4, send 3 bytes, change lane_cfg to x1, then reset=0 for one cycle -> no emit, all outputs/counters 0. After release, one byte 9C in x1 mode -> out0=9C, valid0=1 next cycle.
- lane_cfg=11, send 4 bytes -> treated as x4, cfg_err=1 and stays 1 until reset. Also preload 65535 groups -> next emit wraps grp_cnt to 0.
